// File: rtl/vc_channel_buffer_if.sv
// Router input-channel link bundle: upstream send/ready side and
// downstream send/ready side of one vc_channel_buffer.
interface vc_channel_buffer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2
);
  logic                  si;
  logic [DATA_WIDTH-1:0] di;
  logic [NUM_VC-1:0]     ri;
  logic                  so;
  logic                  ro;
  logic [DATA_WIDTH-1:0] dout;

  modport slave (
    input  si,
    input  di,
    input  ro,
    output ri,
    output so,
    output dout
  );

  modport master (
    output si,
    output di,
    output ro,
    input  ri,
    input  so,
    input  dout
  );
endinterface

// File: rtl/vc_channel_buffer.sv
// Per-port input channel: steers packets into per-VC FIFOs and drains
// one VC per cycle under a free-running rotating phase.
module vc_channel_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_VC       = 2,
  parameter int VC_MSB       = 63,
  parameter int BUFFER_DEPTH = 1,
  parameter int HOP_INC      = 1,
  parameter int HOP_MSB      = 55,
  localparam int VC_W        = $clog2(NUM_VC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [VC_W-1:0] phase,
  output logic            ovf,
  vc_channel_buffer_if.slave bus
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ?
                         $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [NUM_VC][BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_q  [NUM_VC];
  logic [PTR_W-1:0]      wr_d  [NUM_VC];
  logic [PTR_W-1:0]      rd_q  [NUM_VC];
  logic [PTR_W-1:0]      rd_d  [NUM_VC];
  logic [CNT_W-1:0]      cnt_q [NUM_VC];
  logic [CNT_W-1:0]      cnt_d [NUM_VC];
  logic [VC_W-1:0]       phase_q, phase_d;
  logic                  ovf_q, ovf_d;

  logic [VC_W-1:0]       vc_in;
  logic [NUM_VC-1:0]     full;
  logic                  enq, drop, deq, so;
  logic [DATA_WIDTH-1:0] head, hop_pkt;
  logic [7:0]            hop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign vc_in = bus.di[VC_MSB -: VC_W];

  always_comb begin
    full = '0;
    for (int v = 0; v < NUM_VC; v++)
      full[v] = (cnt_q[v] == DEPTH_C);
  end

  assign enq  = bus.si && !full[vc_in];
  assign drop = bus.si &&  full[vc_in];
  assign so   = (cnt_q[phase_q] != '0);
  assign deq  = so && bus.ro;

  assign head = mem_q[phase_q][rd_q[phase_q]];
  assign hop  = head[HOP_MSB -: 8];

  // Hop increment saturates so a looping packet never wraps to 0
  always_comb begin
    hop_pkt = head;
    if (HOP_INC != 0)
      hop_pkt[HOP_MSB -: 8] = (hop == 8'hFF) ? hop : hop + 8'd1;
  end

  always_comb begin
    phase_d = phase_q + VC_W'(1);
    ovf_d   = ovf_q | drop;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_d[v]  = wr_q[v];
      rd_d[v]  = rd_q[v];
      cnt_d[v] = cnt_q[v];
      if (enq && vc_in == VC_W'(v))
        wr_d[v] = nxt(wr_q[v]);
      if (deq && phase_q == VC_W'(v))
        rd_d[v] = nxt(rd_q[v]);
      unique case (1'b1)
        (enq && vc_in == VC_W'(v)) &&
        !(deq && phase_q == VC_W'(v)):
          cnt_d[v] = cnt_q[v] + CNT_W'(1);
        (deq && phase_q == VC_W'(v)) &&
        !(enq && vc_in == VC_W'(v)):
          cnt_d[v] = cnt_q[v] - CNT_W'(1);
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= '0;
      ovf_q   <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_q[v]  <= '0;
        rd_q[v]  <= '0;
        cnt_q[v] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_q[v]  <= wr_d[v];
        rd_q[v]  <= rd_d[v];
        cnt_q[v] <= cnt_d[v];
      end
    end
  end

  // Storage needs no reset: counts gate every read
  always_ff @(posedge clk) begin
    if (reset && enq)
      mem_q[vc_in][wr_q[vc_in]] <= bus.di;
  end

  assign phase    = phase_q;
  assign ovf      = ovf_q;
  assign bus.ri   = ~full;
  assign bus.so   = so;
  assign bus.dout = so ? hop_pkt : '0;

endmodule

// File: doc/vc_channel_buffer.md
# vc_channel_buffer

Parametrised per-port input channel for the mesh router: it accepts 64-bit packets on a send/ready link, steers each into one of NUM_VC virtual-channel FIFOs by the packet's VC field, and drains them one VC per cycle under an internal rotating phase. The rotating phase generalises the router's single polarity bit. The block sits between a router input link (or the PE/NIC injection port) and the router's output arbitration. It adds per-VC backpressure, configurable depth, optional hop-count increment, and overflow detection.

## Interface
- DATA_WIDTH, 64, packet width
- NUM_VC, 2, number of virtual channels; power of two, ≥2; VC_W = log2(NUM_VC)
- VC_MSB, 63, MSB of the VC field; field is di[VC_MSB -: VC_W]
- BUFFER_DEPTH, 1, entries per VC; any integer ≥1, not restricted to a power of two
- HOP_INC, 1, 1 = increment the hop field on dequeue, 0 = pass through
- HOP_MSB, 55, MSB of the 8-bit hop-count field; field is [HOP_MSB -: 8]

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- phase  out  VC_W  current drain phase (the VC being served this cycle)
- si  in  1  upstream send valid
- di  in  DATA_WIDTH  upstream packet
- ri  out  NUM_VC  per-VC ready: bit v = VC v has a free entry
- so  out  1  downstream send valid
- ro  in  1  downstream ready
- do  out  DATA_WIDTH  downstream packet
- ovf  out  1  sticky overflow flag

## Operation
- Reset (reset=0 at a rising edge):
  - all FIFOs empty; all pointers and counts 0; phase=0; ovf=0.
  - Resulting outputs: so=0, ri=all ones, do=0.
  - Reset asserted mid-operation discards all stored packets; nothing is emitted.
- Phase: phase ← (phase+1) mod NUM_VC every cycle out of reset, independent of traffic.
- Enqueue:
  - On a rising edge with si=1, let v = di[VC_MSB -: VC_W].
  - If count[v] < BUFFER_DEPTH: store di at wr_ptr[v], then advance wr_ptr[v] and count[v].
  - If count[v] = BUFFER_DEPTH: drop the packet and set ovf=1. FIFO state is unchanged.
- ri[v] = (count[v] != BUFFER_DEPTH), decoded from registered count only. There is no same-cycle bypass: a full VC shows ri[v]=0 even in a cycle where it dequeues.
- Drain:
  - so = (count[phase] != 0).
  - do = head of FIFO[phase], with the hop field replaced by hop+1 when HOP_INC=1. The increment saturates at 8'hFF.
  - When HOP_INC=1 and so=0, do is driven to 0.
  - Dequeue on a rising edge with so=1 and ro=1: advance rd_ptr[phase] and decrement count[phase].
- Enqueue and dequeue on the same VC in the same cycle: both take effect and count is unchanged. This is only possible when count < DEPTH.
- Pointers wrap from BUFFER_DEPTH-1 to 0.
- Order is FIFO within a VC. There is no ordering guarantee across VCs.
- ovf is sticky and is cleared only by reset.
- The payload outside the hop field is never modified.

## Timing
- so, do, ri and phase are combinational from registered state only. No input→output combinational path exists except ro→(internal dequeue).
- Latency:
  - A packet written at edge k is visible on do no earlier than the cycle after edge k, in the first cycle where phase = its VC.
  - Worst-case wait with an empty VC and ro=1 is NUM_VC cycles.
- Throughput: one dequeue per cycle across the block, and one per NUM_VC cycles per VC.
- ri falls the cycle after the enqueue that fills a VC. It rises the cycle after the dequeue that frees an entry.
- Backpressure: with ro=0 the head is held. so and do reappear unchanged every time phase returns to that VC.

## Test plan
- Reset: hold reset=0 for 2 edges with si=1 → so=0, ri=2'b11, phase=0, ovf=0. phase then reads 1,0,1,… in the following cycles.
- Basic forward (NUM_VC=2, DEPTH=1, HOP_INC=1):
  - Stimulus: inject {1'b1,2'b10,5'b0,8'h10,16'h0,32'h1111_1111} while phase=0, with ro=1.
  - Next cycle (phase=1): ri=2'b01, so=1, do has the hop field equal to 8'h11 and the payload 32'h1111_1111.
  - The following cycle: ri=2'b11, so=0.
- Backpressure:
  - Stimulus: ro=0 with one packet in VC0, held for 6 cycles.
  - so toggles 1,0,1,0,… aligned with phase=0, and do is identical in each phase=0 cycle.
  - Raise ro → the packet is dequeued exactly once.
- Overflow (DEPTH=1):
  - Stimulus: fill VC0, hold ro=0, then send a second VC0 packet 32'h2222_2222.
  - ovf=1 and stays 1.
  - On drain, only 32'h1111_1111 emerges; VC1 traffic is unaffected.
- Wrap/order (DEPTH=3):
  - Stimulus: stream 10 distinct VC1 packets, honouring ri[1], with ro toggling pseudo-randomly.
  - All 10 emerge in order across pointer wrap, with no loss or duplication and ovf=0.
- Hop saturation: an input hop field of 8'hFF → output hop field 8'hFF. With HOP_INC=0, do equals di bit-exact.
